pool_out_buffer: RTL and testbench
==================================

// Module: pool_out_buffer
// PURPOSE
//  Sits directly downstream of the pooler. Captures each pooled value while the pooler flags
//  valid_op, applies optional ReLU and holds one pooled frame ((m/p)^2 words) in a register FIFO.
//  When the pooler flags end_op, it streams the frame out on a valid/ready interface to the
//  next layer (flatten / fully-connected input), tagging the final word and reporting drops.
// PARAMETERS
//  N      16  data word width, signed fixed point
//  Q      12  fractional bits (pass-through only; no arithmetic on Q)
//  DEPTH  16  words per pooled frame = (m/p)^2; default matches m=12, p=3
//  AW     5   count/pointer width; must satisfy 2^AW > DEPTH
//  RELU   1   1: negative inputs stored as 0; 0: stored unchanged
// PORTS
//  clk         in   1      clock, rising edge
//  master_rst  in   1      asynchronous, active-low reset
//  ce          in   1      input-side enable; in_valid/in_end ignored when 0
//  in_data     in   N      pooler data_out
//  in_valid    in   1      pooler valid_op
//  in_end      in   1      pooler end_op: frame input complete
//  out_data    out  N      head-of-FIFO word
//  out_valid   out  1      out_data valid (DRAIN state, FIFO non-empty)
//  out_ready   in   1      downstream accepts out_data this cycle
//  out_last    out  1      out_data is the final word of the frame
//  frame_done  out  1      one-cycle pulse when a frame is fully drained
//  ovf_err     out  1      sticky: a write was dropped
//  count       out  AW     words currently held
// BEHAVIOUR
//  Reset (master_rst=0, async): state=IDLE; pointers, count=0; out_valid, out_last, frame_done,
//   ovf_err=0. out_data undefined-safe: drive 0 while count=0. Array contents are not cleared.
//  Write: accepted on a rising edge when ce=1, in_valid=1, state in {IDLE,FILL}, count<DEPTH.
//   Stored = (RELU && in_data[N-1]) ? 0 : in_data. wr_ptr wraps DEPTH-1 -> 0; count+1.
//  Dropped write: ce=1 and in_valid=1 while count=DEPTH or state=DRAIN -> no store, ovf_err<=1.
//   ovf_err is cleared only by reset.
//  FSM (all transitions qualified by ce except DRAIN exit):
//   IDLE : accepted write -> FILL; in_end=1 -> DRAIN (same-edge write is stored first).
//   FILL : in_end=1 -> DRAIN; a write on the same edge is stored and belongs to this frame.
//   DRAIN: out_valid = (count!=0). Beat = out_valid & out_ready: rd_ptr+1 (wraps), count-1.
//          Beat with count=1 -> IDLE, frame_done pulses the following cycle.
//          Entering DRAIN with count=0 (empty frame) -> IDLE next cycle, frame_done pulse,
//          no beat issued.
//  Output: out_data = mem[rd_ptr], combinational from the register array (no read latency).
//   First out_valid appears the cycle after the edge that samples in_end. out_data/out_valid
//   must hold stable while out_valid=1 and out_ready=0. out_last = out_valid & (count==1).
//   out_ready is ignored outside DRAIN. The output side ignores ce.
//  count: simultaneous write+beat impossible (writes blocked in DRAIN), so count changes by
//   at most 1 per cycle. Throughput: 1 word/cycle each direction.
//  Reset mid-frame or mid-drain: everything aborts to IDLE; partial frame discarded; no
//   frame_done pulse.
//  Bit widths: no arithmetic on data; ReLU is sign test only. No Q-format interpretation.
// TESTING
//  1 RELU=1, 16 writes 0x0100,0xF000,... then in_end, out_ready=1 -> 16 beats, 0xF000 out as
//    0x0000, out_last on beat 16, frame_done one cycle later, count 16->0, ovf_err=0.
//  2 Same frame, out_ready toggled 1010... -> out_data stable when stalled, order preserved,
//    exactly 16 beats over 32 cycles.
//  3 17 writes before in_end -> 17th dropped, ovf_err=1 and stays 1 after frame drains;
//    writes during DRAIN also dropped with count unchanged.
//  4 in_end coincident with 16th in_valid -> word 16 stored, DRAIN entered, 16 beats emitted.
//  5 in_end with no writes -> no out_valid, frame_done pulse after 2 cycles, state IDLE.
//  6 master_rst low after 5 of 16 beats -> out_valid, count, frame_done 0 immediately (async);
//    next frame of 4 words + in_end drains exactly those 4 words. Also ce=0 with in_valid=1
//    -> no store.

Source files
------------

// File: rtl/pool_out_buffer.sv
// pool_out_buffer: captures pooled words (with optional ReLU) into a one-frame
// register FIFO and streams the frame downstream on a valid/ready interface
// once the pooler signals end of frame.
module pool_out_buffer #(
    parameter int N     = 16,
    parameter int Q     = 12,
    parameter int DEPTH = 16,
    parameter int AW    = 5,
    parameter int RELU  = 1
) (
    input  logic          clk,
    input  logic          master_rst,
    input  logic          ce,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    input  logic          in_end,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          frame_done,
    output logic          ovf_err,
    output logic [AW-1:0] count
);

    // Pointer width only needs to address DEPTH entries; count needs AW bits.
    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    // Reject parameter sets that cannot work: count must reach DEPTH, and the
    // fractional field must fit inside the word.
    if ((2 ** AW) <= DEPTH || Q >= N) begin : g_bad_param
        $error("pool_out_buffer: invalid parameters");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic [N-1:0]    mem_q [DEPTH];

    logic            full;
    logic            wr_req;
    logic            wr_acc;
    logic            wr_drop;
    logic            vld;
    logic            beat;
    logic signed [N-1:0] wr_word;

    // ReLU is a pure sign test: negative words become zero when enabled.
    function automatic logic signed [N-1:0] relu_f(input logic signed [N-1:0] x);
        if (RELU != 0 && x[N-1]) begin
            return '0;
        end
        return x;
    endfunction

    // Circular pointer advance with wrap at DEPTH-1.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == LAST_P) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Next-state, pointer, count and flag computation.
    always_comb begin
        full     = (count_q == DEPTH_C);
        wr_req   = ce & in_valid;
        wr_acc   = wr_req && (state_q != ST_DRAIN) && !full;
        wr_drop  = wr_req && ((state_q == ST_DRAIN) || full);
        vld      = (state_q == ST_DRAIN) && (count_q != '0);
        beat     = vld & out_ready;
        wr_word  = relu_f($signed(in_data));

        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | wr_drop;
        done_d   = 1'b0;

        // Writes only happen outside DRAIN and beats only inside it, so the
        // two count updates below are mutually exclusive.
        if (wr_acc) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
            count_d  = count_q + AW'(1);
        end
        if (beat) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
            count_d  = count_q - AW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (ce && in_end) begin
                    state_d = ST_DRAIN;
                end else if (wr_acc) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (ce && in_end) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // An empty frame finishes without ever raising out_valid.
                if (count_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (beat && (count_q == AW'(1))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; a reset aborts any frame in progress.
    always_ff @(posedge clk or negedge master_rst) begin
        if (!master_rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // Frame storage; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    // Output side reads the head word directly from the array.
    always_comb begin
        out_data   = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
        out_valid  = vld;
        out_last   = vld && (count_q == AW'(1));
        frame_done = done_q;
        ovf_err    = ovf_q;
        count      = count_q;
    end

endmodule

// File: tb/tb_pool_out_buffer.sv
module tb_pool_out_buffer;

    localparam int N     = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic [N-1:0]  in_data;
    logic          in_valid;
    logic          in_end;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          frame_done;
    logic          ovf_err;
    logic [AW-1:0] count;

    pool_out_buffer #(.N(N), .Q(12), .DEPTH(DEPTH), .AW(AW), .RELU(1)) dut (
        .clk        (clk),
        .master_rst (rst_n),
        .ce         (ce),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_end     (in_end),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frame_done (frame_done),
        .ovf_err    (ovf_err),
        .count      (count)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int nbeats = 0;
    int ndone  = 0;

    // Reference model: the frame is a queue; draining is "frame handed off".
    logic [N-1:0] mq[$];
    bit           m_drain = 0;
    bit           m_ovf   = 0;
    bit           m_done  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] relu_m(input logic [N-1:0] w);
        return w[N-1] ? '0 : w;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_drain = 0;
        m_ovf   = 0;
        m_done  = 0;
    endtask

    // One clock: check outputs against the model, then advance the model.
    task automatic cyc();
        bit           ev;
        logic [N-1:0] ed;
        ev = m_drain && (mq.size() != 0);
        ed = (mq.size() != 0) ? mq[0] : '0;
        chk("out_valid", out_valid, ev);
        chk("out_data", out_data, ed);
        chk("out_last", out_last, ev && (mq.size() == 1));
        chk("frame_done", frame_done, m_done);
        chk("ovf_err", ovf_err, m_ovf);
        chk("count", count, mq.size());
        if (out_valid && out_ready) nbeats++;
        if (frame_done) ndone++;
        @(posedge clk);
        m_done = 0;
        if (!m_drain) begin
            if (ce && in_valid) begin
                if (mq.size() < DEPTH) mq.push_back(relu_m(in_data));
                else m_ovf = 1;
            end
            if (ce && in_end) m_drain = 1;
        end else begin
            if (ce && in_valid) m_ovf = 1;
            if (mq.size() == 0) begin
                m_drain = 0;
                m_done  = 1;
            end else if (out_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    m_drain = 0;
                    m_done  = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit c, input bit v, input bit e, input logic [N-1:0] d, input bit r);
        ce        = c;
        in_valid  = v;
        in_end    = e;
        in_data   = d;
        out_ready = r;
        cyc();
    endtask

    function automatic logic [N-1:0] pat(input int i);
        return (i % 2) ? N'(16'hF000 + i) : N'(16'h0100 + i);
    endfunction

    // Fill n words (optionally with in_end on the last write), then in_end.
    task automatic fill(input int n, input bit end_on_last);
        for (int i = 0; i < n; i++)
            drive(1, 1, end_on_last && (i == n - 1), pat(i), 0);
        if (!end_on_last) drive(1, 0, 1, '0, 0);
    endtask

    task automatic drain(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++)
            drive(1, 0, 0, '0, (mode == 0) ? 1'b1 : (mode == 1) ? 1'(i % 2 == 0) : 1'($urandom_range(0, 1)));
    endtask

    initial begin
        rst_n = 0; ce = 0; in_valid = 0; in_end = 0; in_data = '0; out_ready = 0;
        #12;
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_data", out_data, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Full frame, ready always high.
        nbeats = 0; ndone = 0;
        fill(16, 0);
        chk("t1_count_full", count, 16);
        drain(20, 0);
        chk("t1_beats", nbeats, 16);
        chk("t1_done", ndone, 1);
        chk("t1_ovf", ovf_err, 0);

        // Same frame, ready toggling.
        nbeats = 0; ndone = 0;
        fill(16, 0);
        drain(32, 1);
        chk("t2_beats", nbeats, 16);
        drain(3, 0);
        chk("t2_done", ndone, 1);

        // 17 writes, then writes during drain.
        fill(17, 0);
        chk("t3_ovf", ovf_err, 1);
        for (int i = 0; i < 30; i++)
            drive(1, 1'($urandom_range(0, 1)), 0, N'($urandom), 1'($urandom_range(0, 1)));
        drain(30, 0);
        chk("t3_ovf_sticky", ovf_err, 1);

        // in_end coincident with the 16th write.
        nbeats = 0;
        fill(16, 1);
        drain(20, 0);
        chk("t4_beats", nbeats, 16);

        // Empty frame.
        nbeats = 0; ndone = 0;
        drive(1, 0, 1, '0, 1);
        drain(4, 0);
        chk("t5_beats", nbeats, 0);
        chk("t5_done", ndone, 1);

        // Reset mid-drain after 5 beats.
        fill(16, 0);
        drain(5, 0);
        #2 rst_n = 0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_count", count, 0);
        chk("t6_done", frame_done, 0);
        chk("t6_ovf", ovf_err, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) drive(0, 1, 0, N'($urandom), 1);
        chk("t6_ce_off", count, 0);
        nbeats = 0;
        for (int i = 0; i < 4; i++) drive(1, 1, 0, N'($urandom), 0);
        drive(1, 0, 1, '0, 0);
        drain(8, 0);
        chk("t6_beats", nbeats, 4);

        // Random frames with gaps, ce noise and random backpressure.
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(0, 18);
            for (int i = 0; i < n; i++)
                drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 0, N'($urandom), 1'($urandom_range(0, 1)));
            drive(1, 1'($urandom_range(0, 1)), 1, N'($urandom), 0);
            for (int i = 0; i < 45; i++)
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 0, N'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
